// File: rtl/key_event_decoder.sv
// Key gesture classifier: short press, double click, long press, auto-repeat.
// Takes an already-debounced key level and emits one-cycle registered pulses.
module key_event_decoder #(
    parameter int LONG_CYC   = 10000000,
    parameter int DBL_CYC    = 3000000,
    parameter int REPEAT_CYC = 2000000,
    parameter int CNT_W      = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic key_level,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             key_q;
    logic             key_q_d;
    logic             armed;
    logic             press_edge;

    // armed stays low until a released key is seen, so a key held across
    // reset never produces a press edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q   <= 1'b0;
            key_q_d <= 1'b0;
            armed   <= 1'b0;
        end else begin
            key_q   <= key_level;
            key_q_d <= key_q;
            armed   <= armed | ~key_level;
        end
    end

    assign press_edge = key_q & ~key_q_d & armed;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (press_edge) begin
                        state <= PRESS1;
                    end
                end
                PRESS1: begin
                    if (!key_q) begin
                        state <= WAIT2;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        long_press <= 1'b1;
                        state      <= HOLD;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT2: begin
                    if (press_edge) begin
                        double_click <= 1'b1;
                        state        <= PRESS2;
                        cnt          <= '0;
                    end else if (cnt == DBL_LAST) begin
                        short_press <= 1'b1;
                        state       <= IDLE;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESS2: begin
                    cnt <= '0;
                    if (!key_q) begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (!key_q) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == REP_LAST) begin
                        repeat_pulse <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: a run-length gesture model predicts
// event pulses and their cycle stamps; a negedge monitor pops and compares.
module tb_key_event_decoder;

    localparam int LONG = 20;
    localparam int DBL  = 10;
    localparam int REP  = 5;

    localparam int K_SHORT = 0;
    localparam int K_DBL   = 1;
    localparam int K_LONG  = 2;
    localparam int K_REP   = 3;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_level = 1'b0;
    logic short_press;
    logic double_click;
    logic long_press;
    logic repeat_pulse;
    logic busy;

    ev_t exp_q[$];
    bit  seq[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    key_event_decoder #(
        .LONG_CYC  (LONG),
        .DBL_CYC   (DBL),
        .REPEAT_CYC(REP),
        .CNT_W     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_level   (key_level),
        .short_press (short_press),
        .double_click(double_click),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, got, want, cyc);
        end
    endfunction

    function automatic void add(input bit v, input int len);
        for (int i = 0; i < len; i++) seq.push_back(v);
    endfunction

    function automatic void push(input int e, input int k, input int n, input int c0);
        ev_t x;
        if (e < n) begin
            x.cyc  = c0 + 1 + e;
            x.kind = k;
            exp_q.push_back(x);
        end
    endfunction

    // Index i of seq is the level held by the key register after edge i.
    // A rise at index p counts only if index p-1 was a real low sample.
    function automatic void model(input int n, input int c0);
        int t, p, r, s, e;
        t = 1;
        while (t < n) begin
            if (seq[t] && !seq[t-1]) begin
                p = t;
                r = p;
                while (r < n && seq[r]) r++;
                if (r - p > LONG) begin
                    push(p + LONG + 1, K_LONG, n, c0);
                    for (e = p + LONG + 1 + REP; e <= r; e += REP)
                        push(e, K_REP, n, c0);
                    t = r + 1;
                end else begin
                    s = r + 1;
                    while (s < n && !seq[s]) s++;
                    if (s < n && s <= r + DBL) begin
                        push(s + 1, K_DBL, n, c0);
                        r = s;
                        while (r < n && seq[r]) r++;
                        t = r + 1;
                    end else begin
                        push(r + 1 + DBL, K_SHORT, n, c0);
                        t = r + 1;
                    end
                end
            end else begin
                t++;
            end
        end
    endfunction

    always @(negedge clk) begin
        int   np;
        int   k;
        ev_t  ex;
        if (!rst) begin
            np = int'(short_press) + int'(double_click) +
                 int'(long_press) + int'(repeat_pulse);
            if (np != 0) begin
                chk("onehot", np, 1);
                k = short_press  ? K_SHORT :
                    double_click ? K_DBL   :
                    long_press   ? K_LONG  : K_REP;
                chk("busy_at_pulse", int'(busy), (k == K_SHORT) ? 0 : 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", k, -1);
                end else begin
                    ex = exp_q.pop_front();
                    chk("ev_kind", k, ex.kind);
                    chk("ev_cyc", cyc, ex.cyc);
                end
            end
        end
    end

    function automatic int outs();
        return int'({short_press, double_click, long_press, repeat_pulse, busy});
    endfunction

    task automatic run_seq(input int abort_at);
        int n;
        int lim;
        int c0;
        n   = seq.size();
        lim = (abort_at > 0) ? abort_at : n;
        rst = 1'b1;
        key_level = seq[0];
        repeat (2) @(negedge clk);
        chk("reset_outs", outs(), 0);
        rst = 1'b0;
        c0  = cyc;
        model(lim, c0);
        for (int i = 0; i < lim; i++) begin
            key_level = seq[i];
            @(negedge clk);
        end
        if (abort_at > 0) begin
            @(posedge clk);
            #2 rst = 1'b1;
            #1 chk("async_reset_outs", outs(), 0);
        end else begin
            repeat (2) @(negedge clk);
            chk("idle_busy", int'(busy), 0);
        end
        chk("pending_events", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        seq.delete(); add(0, 2); add(1, 5); add(0, 40);
        run_seq(0);
        seq.delete(); add(0, 2); add(1, 5); add(0, 4); add(1, 3); add(0, 40);
        run_seq(0);
        seq.delete(); add(0, 2); add(1, 40); add(0, 40);
        run_seq(0);
        seq.delete(); add(0, 2); add(1, 20); add(0, 40);
        run_seq(0);
        seq.delete(); add(0, 2); add(1, 20); add(0, 10); add(1, 3); add(0, 40);
        run_seq(0);
        seq.delete(); add(0, 2); add(1, 20); add(0, 11); add(1, 3); add(0, 40);
        run_seq(0);
        seq.delete(); add(0, 2); add(1, 21); add(0, 40);
        run_seq(0);
        seq.delete(); add(0, 2); add(1, 3); add(0, 3); add(1, 3); add(0, 3);
        add(1, 3); add(0, 40);
        run_seq(0);
        seq.delete(); add(0, 2); add(1, 40);
        run_seq(30);
        seq.delete(); add(1, 10); add(0, 3); add(1, 25); add(0, 40);
        run_seq(0);
        seq.delete(); add(1, 30); add(0, 40);
        run_seq(0);
        for (int r = 0; r < 40; r++) begin
            seq.delete();
            add(0, 2);
            for (int j = 0; j < int'($urandom_range(2, 6)); j++) begin
                add(1, int'($urandom_range(1, 32)));
                add(0, int'($urandom_range(1, 16)));
            end
            add(0, 40);
            run_seq(0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
